mesh_egress_unpacker: RTL and testbench

- Egress adapter at a mesh output port; the receive-side counterpart of the ingress packing path.
- Accepts flits from the mesh, where user bits travel packed in the upper tdata bits ({tuser, data}), and unpacks them back into separate AXI-S tdata/tuser.
- Buffers beats in a small FIFO and enforces a maximum packet length.
- Presents a clean AXI-S master to a host port or a consumer MVM.

---
 rtl/mesh_egress_unpacker_pkg.sv | 26 ++
 rtl/mesh_egress_unpacker_fifo.sv | 48 ++++
 rtl/mesh_egress_unpacker.sv | 142 ++++++++++++++
 tb/tb_mesh_egress_unpacker.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_egress_unpacker_pkg.sv
// Shared types for the mesh egress unpacker: ingress FSM states, the buffered beat
// layout and the packed-flit width helper.
package mesh_egress_unpacker_pkg;

    localparam int DEF_DATAW = 512;
    localparam int DEF_USERW = 8;
    localparam int DEF_DESTW = 4;

    typedef enum logic {
        PASS = 1'b0,
        DROP = 1'b1
    } egress_state_e;

    typedef struct packed {
        logic [DEF_USERW-1:0] user;
        logic [DEF_DATAW-1:0] data;
        logic [DEF_DESTW-1:0] dest;
        logic                 last;
    } egress_beat_t;

    // Mesh flits carry the user bits above the payload: {tuser, tdata}.
    function automatic int tdata_width(input int dataw, input int userw);
        return dataw + userw;
    endfunction

endpackage

// File: rtl/mesh_egress_unpacker_fifo.sv
// egress_fifo: synchronous FIFO of egress beats with wrap-bit pointers; the head is
// read straight from registered storage so it holds steady until popped.
module egress_fifo
    import mesh_egress_unpacker_pkg::*;
#(
    parameter type beat_t = egress_beat_t,
    parameter int  DEPTH  = 16
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  logic  pop,
    input  beat_t din,
    output logic  full,
    output logic  empty,
    output beat_t head
);

    localparam int AW = $clog2(DEPTH);

    beat_t          mem [DEPTH];
    logic  [AW:0]   wptr;
    logic  [AW:0]   rptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage carries no reset; the top masks the head while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mesh_egress_unpacker.sv
// Mesh egress adapter: unpacks {tuser, tdata} flits into AXI-S tdata/tuser, buffers them
// and truncates over-long packets. Define MESH_EGRESS_STATS_EN to add pkt/drop counters.
module mesh_egress_unpacker
    import mesh_egress_unpacker_pkg::*;
#(
    parameter int DATAW     = 512,
    parameter int USERW     = 8,
    parameter int DESTW     = 4,
    parameter int TDATAW    = tdata_width(DATAW, USERW),
    parameter int FIFOD     = 16,
    parameter int MAX_BEATS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic [TDATAW-1:0] s_tdata,
    input  logic              s_tlast,
    input  logic [DESTW-1:0]  s_tdest,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATAW-1:0]  m_tdata,
    output logic [USERW-1:0]  m_tuser,
    output logic              m_tlast,
    output logic [DESTW-1:0]  m_tdest,
    output logic              err_len,
`ifdef MESH_EGRESS_STATS_EN
    output logic [31:0]       pkt_count,
    output logic [31:0]       drop_count,
`endif
    output egress_state_e     fsm_state
);

    // Handshakes: a beat moves on a channel only in a cycle where valid && ready at the
    // rising edge; once valid is high its payload holds until that cycle.

    localparam int CW = $clog2(MAX_BEATS);

    typedef struct packed {
        logic [USERW-1:0] user;
        logic [DATAW-1:0] data;
        logic [DESTW-1:0] dest;
        logic             last;
    } beat_t;

    egress_state_e   state;
    egress_state_e   state_nx;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nx;
    logic            err_nx;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    beat_t           wr_beat;
    beat_t           head;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        err_nx   = err_len;
        push     = 1'b0;
        s_tready = 1'b0;
        wr_beat  = '{user: s_tdata[TDATAW-1:DATAW], data: s_tdata[DATAW-1:0],
                     dest: s_tdest, last: s_tlast};
        if (!rst) begin
            case (state)
                PASS: begin
                    s_tready = !full;
                    if (s_tvalid && !full) begin
                        push = 1'b1;
                        if (s_tlast) begin
                            cnt_nx = '0;
                        end else if (cnt == CW'(MAX_BEATS - 1)) begin
                            // Close the packet here; the rest of it is swallowed in DROP.
                            wr_beat.last = 1'b1;
                            err_nx       = 1'b1;
                            state_nx     = DROP;
                        end else begin
                            cnt_nx = cnt + 1'b1;
                        end
                    end
                end
                DROP: begin
                    s_tready = 1'b1;
                    if (s_tvalid && s_tlast) begin
                        state_nx = PASS;
                        cnt_nx   = '0;
                    end
                end
                default: state_nx = PASS;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= PASS;
            cnt     <= '0;
            err_len <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            err_len <= err_nx;
        end
    end

    egress_fifo #(
        .beat_t (beat_t),
        .DEPTH  (FIFOD)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (wr_beat),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    assign m_tvalid  = !empty;
    assign pop       = m_tvalid && m_tready;
    assign m_tdata   = empty ? '0 : head.data;
    assign m_tuser   = empty ? '0 : head.user;
    assign m_tdest   = empty ? '0 : head.dest;
    assign m_tlast   = empty ? 1'b0 : head.last;
    assign fsm_state = state;

`ifdef MESH_EGRESS_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            if (pop && head.last) pkt_count <= pkt_count + 32'd1;
            if (state == DROP && s_tvalid) drop_count <= drop_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mesh_egress_unpacker.sv
// Self-checking bench for mesh_egress_unpacker: packet table, hand sequences for latency,
// backpressure and mid-packet reset, plus randomized traffic against a packet-level model.
`timescale 1ns/1ps
module tb_mesh_egress_unpacker;
    import mesh_egress_unpacker_pkg::*;

    localparam int DATAW     = 512;
    localparam int USERW     = 8;
    localparam int DESTW     = 4;
    localparam int TDATAW    = DATAW + USERW;
    localparam int FIFOD     = 16;
    localparam int MAX_BEATS = 64;
    localparam int BW        = USERW + DATAW + DESTW + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_tvalid;
    logic              s_tready;
    logic [TDATAW-1:0] s_tdata;
    logic              s_tlast;
    logic [DESTW-1:0]  s_tdest;
    logic              m_tvalid;
    logic              m_tready;
    logic [DATAW-1:0]  m_tdata;
    logic [USERW-1:0]  m_tuser;
    logic              m_tlast;
    logic [DESTW-1:0]  m_tdest;
    logic              err_len;
`ifdef MESH_EGRESS_STATS_EN
    logic [31:0]       pkt_count;
    logic [31:0]       drop_count;
`endif
    egress_state_e     fsm_state;

    mesh_egress_unpacker #(
        .DATAW(DATAW), .USERW(USERW), .DESTW(DESTW), .FIFOD(FIFOD), .MAX_BEATS(MAX_BEATS)
    ) dut (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tlast(s_tlast), .s_tdest(s_tdest),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tuser(m_tuser), .m_tlast(m_tlast), .m_tdest(m_tdest),
        .err_len(err_len),
`ifdef MESH_EGRESS_STATS_EN
        .pkt_count(pkt_count), .drop_count(drop_count),
`endif
        .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int out_beats = 0;
    int ready_mode = 0;  // 0: always ready, 1: never ready, 2: random 50%
    bit abort = 1'b0;

    // ---------------- reference model state ----------------
    logic [BW-1:0] exp_q[$];
    bit  exp_err = 1'b0;
    int  exp_pkts = 0;
    int  exp_drops = 0;

    function automatic logic [DATAW-1:0] mk_data(input logic [31:0] seed, input int i);
        logic [DATAW-1:0] d;
        d = '0;
        d[31:0] = seed + 32'(i);
        d[DATAW-1 -: 32] = seed;
        return d;
    endfunction

    // A packet keeps its first MAX_BEATS beats; the last kept beat always carries tlast.
    function automatic void model_packet(input int len, input logic [USERW-1:0] u,
                                         input logic [DESTW-1:0] de, input logic [31:0] seed);
        int kept;
        kept = (len > MAX_BEATS) ? MAX_BEATS : len;
        for (int i = 0; i < kept; i++)
            exp_q.push_back({u, mk_data(seed, i), de, (i == kept - 1)});
        if (len > MAX_BEATS) begin
            exp_err = 1'b1;
            exp_drops += len - MAX_BEATS;
        end
        exp_pkts++;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // ---------------- downstream ready driver ----------------
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = 1'b0;
            default: m_tready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- scoreboard / stability monitor ----------------
    bit            hold_q = 1'b0;
    logic [BW-1:0] hold_v;
    logic [BW-1:0] mon_act;
    logic [BW-1:0] mon_exp;

    always @(negedge clk) begin
        if (rst) begin
            hold_q = 1'b0;
        end else begin
            mon_act = {m_tuser, m_tdata, m_tdest, m_tlast};
            if (hold_q) begin
                checks++;
                if (!m_tvalid || mon_act !== hold_v) begin
                    errors++;
                    $display("FAIL stable: valid=%0b got %h held %h", m_tvalid, mon_act, hold_v);
                end
            end
            if (m_tvalid && m_tready) begin
                checks++;
                out_beats++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat: got unexpected %h expected none", mon_act);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_act !== mon_exp) begin
                        errors++;
                        $display("FAIL beat: got %h expected %h", mon_act, mon_exp);
                    end
                end
            end
            hold_q = m_tvalid && !m_tready;
            hold_v = mon_act;
        end
    end

    // ---------------- ingress driver tasks (entered at posedge+1) ----------------
    task automatic send_beat(input logic [DATAW-1:0] d, input logic [USERW-1:0] u,
                             input logic [DESTW-1:0] de, input logic l, input bit gaps);
        int budget;
        if (abort) return;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end
        s_tdata  = {u, d};
        s_tdest  = de;
        s_tlast  = l;
        s_tvalid = 1'b1;
        budget   = 0;
        forever begin
            @(negedge clk);
            if (s_tready) break;
            budget++;
            if (budget > 3000) begin
                checks++;
                errors++;
                $display("FAIL ingress_timeout: got s_tready=0 expected 1 within 3000 cycles");
                abort = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send_packet(input int len, input logic [USERW-1:0] u,
                               input logic [DESTW-1:0] de, input logic [31:0] seed, input bit gaps);
        model_packet(len, u, de, seed);
        for (int i = 0; i < len; i++)
            send_beat(mk_data(seed, i), u, de, (i == len - 1), gaps);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d beats outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    // ---------------- packet table ----------------
    typedef struct {
        int               len;
        logic [USERW-1:0] user;
        logic [DESTW-1:0] dest;
        logic [31:0]      seed;
        int               exp_beats;
        bit               exp_err;
        int               exp_drop;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int start;
        int acc;
        int k;
        int total;
        int len;

        vecs[0] = '{4,  8'hA5, 4'h3, 32'h0,   4,  1'b0, 0};
        vecs[1] = '{64, 8'h11, 4'h1, 32'h200, 64, 1'b0, 0};
        vecs[2] = '{70, 8'h22, 4'h2, 32'h300, 64, 1'b1, 6};
        vecs[3] = '{2,  8'h33, 4'h4, 32'h400, 2,  1'b1, 6};

        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tdest  = '0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        rst      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_s_tready", s_tready, 1);
        check("post_rst_m_tvalid", m_tvalid, 0);
        check("post_rst_err_len", err_len, 0);
        check("post_rst_m_tdata", m_tdata[63:0], 0);
        check("post_rst_m_tlast", m_tlast, 0);
        check("post_rst_state", fsm_state, PASS);
        @(posedge clk); #1;

        // One-cycle latency from accept to m_tvalid on an empty FIFO.
        model_packet(1, 8'h3C, 4'h7, 32'h1000);
        s_tdata  = {8'h3C, mk_data(32'h1000, 0)};
        s_tdest  = 4'h7;
        s_tlast  = 1'b1;
        s_tvalid = 1'b1;
        @(negedge clk);
        check("lat_before_accept", m_tvalid, 0);
        check("lat_ready", s_tready, 1);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        @(negedge clk);
        check("lat_after_accept", m_tvalid, 1);
        @(posedge clk); #1;
        drain();

        for (int v = 0; v < 4; v++) begin
            start = out_beats;
            send_packet(vecs[v].len, vecs[v].user, vecs[v].dest, vecs[v].seed, 1'b0);
            drain();
            check($sformatf("vec%0d_beats", v), out_beats - start, vecs[v].exp_beats);
            check($sformatf("vec%0d_err_len", v), err_len, vecs[v].exp_err);
            check($sformatf("vec%0d_state", v), fsm_state, PASS);
`ifdef MESH_EGRESS_STATS_EN
            check($sformatf("vec%0d_drop_count", v), drop_count, vecs[v].exp_drop);
`endif
        end

        // Backpressure: 20 beats offered with no drain; only FIFOD fit.
        ready_mode = 1;
        @(posedge clk); #1;
        model_packet(20, 8'h44, 4'h5, 32'h500);
        acc = 0;
        k   = 0;
        for (int c = 0; c < 40; c++) begin
            s_tdata  = {8'h44, mk_data(32'h500, k)};
            s_tdest  = 4'h5;
            s_tlast  = (k == 19);
            s_tvalid = (k < 20);
            @(negedge clk);
            if (s_tvalid && s_tready) begin
                acc++;
                k++;
            end
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0;
        check("bp_accepts", acc, FIFOD);
        check("bp_s_tready_low", s_tready, 0);
        check("bp_m_tvalid", m_tvalid, 1);
        start = out_beats;
        ready_mode = 0;
        for (int i = k; i < 20; i++)
            send_beat(mk_data(32'h500, i), 8'h44, 4'h5, (i == 19), 1'b0);
        drain();
        check("bp_out_beats", out_beats - start, 20);

        // Randomized mixed-length traffic with random valid gaps and random ready.
        ready_mode = 2;
        total = 0;
        while (total < 1000 && !abort) begin
            len = $urandom_range(1, MAX_BEATS);
            send_packet(len, USERW'($urandom), DESTW'($urandom), $urandom, 1'b1);
            total += len;
        end
        ready_mode = 0;
        drain();
        check("rand_err_len", err_len, exp_err);
`ifdef MESH_EGRESS_STATS_EN
        check("rand_pkt_count", pkt_count, exp_pkts);
        check("rand_drop_count", drop_count, exp_drops);
`endif

        // Reset mid-packet with five beats sitting in the FIFO.
        ready_mode = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++)
            send_beat(mk_data(32'h600, i), 8'h55, 4'h6, 1'b0, 1'b0);
        check("midrst_pre_valid", m_tvalid, 1);
        check("midrst_pre_err", err_len, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_s_tready", s_tready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        exp_err   = 1'b0;
        exp_pkts  = 0;
        exp_drops = 0;
        @(negedge clk);
        check("midrst_m_tvalid", m_tvalid, 0);
        check("midrst_err_len", err_len, 0);
        check("midrst_s_tready_after", s_tready, 1);
`ifdef MESH_EGRESS_STATS_EN
        check("midrst_pkt_count", pkt_count, 0);
        check("midrst_drop_count", drop_count, 0);
`endif
        @(posedge clk); #1;
        ready_mode = 0;
        start = out_beats;
        send_packet(MAX_BEATS, 8'h66, 4'h8, 32'h700, 1'b0);
        drain();
        check("post_rst_full_pkt_beats", out_beats - start, MAX_BEATS);
        check("post_rst_full_pkt_err", err_len, 0);
`ifdef MESH_EGRESS_STATS_EN
        check("final_pkt_count", pkt_count, exp_pkts);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
